// File: rtl/solve_pkg.sv
// Shared encodings for the solve sequencer: FSM state codes and fail reasons.
package solve_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STORE   = 3'd1;
    localparam logic [2:0] S_NETWORK = 3'd2;
    localparam logic [2:0] S_CUBE    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;

    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_LIMIT   = 2'b01;
    localparam logic [1:0] FAIL_TIMEOUT = 2'b10;
    localparam logic [1:0] FAIL_ABORT   = 2'b11;

endpackage

// File: rtl/solve_hist.sv
// Move-history buffer: one write per applied move, registered read that returns 0
// for any index not yet written in the current run.
module solve_hist #(
    parameter int MOVE_W = 4,
    parameter int DEPTH  = 10,
    parameter int ADDR_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MOVE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [MOVE_W-1:0] rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MOVE_W-1:0] mem [0:DEPTH-1];

    // NOTE: the storage array has no reset; stale entries are hidden by the count mask,
    // so resetting it would only add a wide reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < ADDR_W'(DEPTH))) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if ((rd_addr < count) && (rd_addr < ADDR_W'(DEPTH))) begin
            rd_data <= mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/solve_ctrl.sv
// Solve sequencer: STORE -> (NETWORK -> CUBE)* -> DONE/FAIL with step limit, watchdog
// and abort. Define SOLVE_CTRL_HIST_EN to build the readable move-history buffer.
module solve_ctrl
    import solve_pkg::*;
#(
    parameter int STATE_W   = 120,
    parameter int MOVE_W    = 4,
    parameter int MAX_STEPS = 10,
    parameter int TIMEOUT   = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic                             abort,
    input  logic [STATE_W-1:0]               init_state,
    output logic                             cube_store,
    output logic                             cube_load,
    output logic [STATE_W-1:0]               cube_data,
    output logic [MOVE_W-1:0]                cube_move,
    input  logic                             cube_valid,
    input  logic                             cube_solved,
    output logic                             net_load,
    input  logic                             net_valid,
    input  logic [MOVE_W-1:0]                net_move,
    output logic                             busy,
    output logic                             done,
    output logic                             fail,
    output logic [1:0]                       fail_code,
    output logic [$clog2(MAX_STEPS+1)-1:0]   step_cnt,
    output logic [MOVE_W-1:0]                last_move,
    input  logic [$clog2(MAX_STEPS+1)-1:0]   hist_rd_addr,
    output logic [MOVE_W-1:0]                hist_rd_data
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);
    localparam int WD_W  = $clog2(TIMEOUT);

    logic [2:0]        state;
    logic [MOVE_W-1:0] move_reg;
    logic [WD_W-1:0]   wd_cnt;
    logic              phase_valid;
    logic [CNT_W-1:0]  step_next;

    assign cube_store = (state == S_STORE);
    assign cube_load  = (state == S_CUBE);
    assign net_load   = (state == S_NETWORK);
    assign busy       = cube_store | cube_load | net_load;
    assign done       = (state == S_DONE);
    assign fail       = (state == S_FAIL);
    assign cube_data  = init_state;
    assign cube_move  = move_reg;

    // Saturating increment keeps step_cnt from ever wrapping past the limit.
    assign step_next = (step_cnt == CNT_W'(MAX_STEPS)) ? step_cnt : step_cnt + CNT_W'(1);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        phase_valid = 1'b0;
        case (state)
            S_STORE, S_CUBE: phase_valid = cube_valid;
            S_NETWORK:       phase_valid = net_valid;
            default:         phase_valid = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fail_code <= FAIL_NONE;
            step_cnt  <= '0;
            last_move <= '0;
            move_reg  <= '0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (run) begin
                        state     <= S_STORE;
                        step_cnt  <= '0;
                        last_move <= '0;
                        fail_code <= FAIL_NONE;
                        wd_cnt    <= '0;
                    end
                end
                S_STORE, S_NETWORK, S_CUBE: begin
                    if (abort) begin
                        state     <= S_FAIL;
                        fail_code <= FAIL_ABORT;
                        wd_cnt    <= '0;
                    end else if (phase_valid) begin
                        wd_cnt <= '0;
                        if (state == S_STORE) begin
                            state <= cube_solved ? S_DONE : S_NETWORK;
                        end else if (state == S_NETWORK) begin
                            move_reg <= net_move;
                            state    <= S_CUBE;
                        end else begin
                            step_cnt  <= step_next;
                            last_move <= move_reg;
                            if (cube_solved) begin
                                state <= S_DONE;
                            end else if (step_next == CNT_W'(MAX_STEPS)) begin
                                state     <= S_FAIL;
                                fail_code <= FAIL_LIMIT;
                            end else begin
                                state <= S_NETWORK;
                            end
                        end
                    end else if (wd_cnt == WD_W'(TIMEOUT - 2)) begin
                        // Counter would reach TIMEOUT-1 this edge: give up on the sub-unit.
                        state     <= S_FAIL;
                        fail_code <= FAIL_TIMEOUT;
                        wd_cnt    <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

`ifdef SOLVE_CTRL_HIST_EN
    solve_hist #(
        .MOVE_W (MOVE_W),
        .DEPTH  (MAX_STEPS),
        .ADDR_W (CNT_W)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cube_load && cube_valid && !abort),
        .wr_addr (step_cnt),
        .wr_data (move_reg),
        .rd_addr (hist_rd_addr),
        .count   (step_cnt),
        .rd_data (hist_rd_data)
    );
`else
    logic unused_hist_rd_addr;
    assign unused_hist_rd_addr = ^hist_rd_addr;
    assign hist_rd_data        = '0;
`endif

endmodule

// File: doc/solve_ctrl.md
# solve_ctrl

Parametrised solve sequencer for the cube datapath. It loads an initial cube state, then alternates network inference and cube move application until the cube reports solved, a step limit is hit, a sub-unit times out, or the host aborts. It sits at the top of the solver, between the host register interface and the cube/network units. It adds explicit fail reasons, a per-phase watchdog, abort, and an optional move-history buffer.

## Interface
- STATE_W, 120, width of packed cube state
- MOVE_W, 4, width of a move code
- MAX_STEPS, 10, move limit before declaring failure (≥1)
- TIMEOUT, 1024, max cycles waiting on any sub-unit valid (≥2)
- CNT_W, $clog2(MAX_STEPS+1), step counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- run  in  1  start pulse; sampled in IDLE/DONE/FAIL only
- abort  in  1  force FAIL from any busy state
- init_state  in  STATE_W  initial cube state, forwarded to cube unit
- cube_store  out  1  level, high throughout STORE
- cube_load  out  1  level, high throughout CUBE
- cube_data  out  STATE_W  equals init_state (combinational pass-through)
- cube_move  out  MOVE_W  move to apply, valid while cube_load
- cube_valid  in  1  cube unit finished current store/move
- cube_solved  in  1  qualified by cube_valid
- net_load  out  1  level, high throughout NETWORK
- net_valid  in  1  network produced a move
- net_move  in  MOVE_W  qualified by net_valid
- busy  out  1  state ∈ {STORE, NETWORK, CUBE}
- done  out  1  high in DONE
- fail  out  1  high in FAIL
- fail_code  out  2  00 none, 01 step limit, 10 timeout, 11 abort
- step_cnt  out  CNT_W  moves applied this run
- last_move  out  MOVE_W  most recently applied move
- hist_rd_addr  in  CNT_W  history read index
- hist_rd_data  out  MOVE_W  history read data

## Operation
- States: IDLE, STORE, NETWORK, CUBE, DONE, FAIL. Moore strobes are decoded from the state register.
- IDLE/DONE/FAIL + run → STORE. Clears step_cnt, last_move, fail_code and watchdog.
- STORE + cube_valid: cube_solved → DONE (0 steps); else → NETWORK.
- NETWORK + net_valid → CUBE. net_move is captured into move_reg, which drives cube_move.
- CUBE + cube_valid: step_cnt += 1; last_move ← move_reg; history[step_cnt] ← move_reg. Then:
  - cube_solved → DONE;
  - else if new step_cnt == MAX_STEPS → FAIL/01;
  - else → NETWORK.
- Solved on the last allowed step wins: DONE, not FAIL.
- Watchdog: counter cleared on every state entry. It increments each cycle in STORE/NETWORK/CUBE without the qualifying valid. At TIMEOUT-1 → FAIL/10.
- Priority in one cycle: rst > abort > valid > timeout.
- abort in IDLE/DONE/FAIL is ignored. run while busy is ignored.
- Valid inputs are ignored outside their own state; stray pulses have no effect.
- step_cnt saturates at MAX_STEPS and never wraps.

## Timing
- Reset: state IDLE; every output 0; move_reg 0; watchdog 0. History contents are don't-care, but hist_rd_data reads 0.
- Strobes assert the cycle the state is entered.
- A strobe drops in the cycle after its valid is sampled, so there is always ≥1 cycle low between phases.
- run → cube_store high: 1 cycle.
- net_valid → cube_load high: 1 cycle.
- Status outputs (done, fail, fail_code, step_cnt, last_move) update in the same edge as the state transition.
- hist_rd_data is registered: 1-cycle latency from hist_rd_addr. It reads 0 when hist_rd_addr ≥ step_cnt.
- Reset mid-run: return to IDLE next edge; all strobes low immediately after.

## Configuration
- SOLVE_CTRL_HIST_EN defined: MAX_STEPS×MOVE_W history buffer is instantiated and read per Timing.
- SOLVE_CTRL_HIST_EN undefined: no storage; hist_rd_data tied 0. All other behaviour is identical.

## Structure
- Shared package solve_pkg holds:
  - state encodings (3-bit);
  - fail_code constants FAIL_NONE/LIMIT/TIMEOUT/ABORT.
- Sub-module solve_hist: write port (en, addr, data), registered read port with the addr-vs-count zero mask. Instantiated only under SOLVE_CTRL_HIST_EN.

## Test plan
- Already solved: run, cube_valid+cube_solved in STORE → done=1, step_cnt=0, fail_code=00, net_load never high.
- Three-move solve:
  - Stimulus: network returns moves 3, 7, 1; cube_solved on third cube_valid.
  - Response: done=1, step_cnt=3, last_move=1, history[0..2]=3,7,1, hist_rd_data@3=0.
- Step limit:
  - Stimulus: MAX_STEPS=4, never solved.
  - Response: FAIL, fail_code=01, step_cnt=4. Solved on the 4th step instead → DONE.
- Timeout: TIMEOUT=16, withhold net_valid → fail_code=10 exactly 15 cycles after NETWORK entry; strobes low.
- Abort collision: abort and cube_valid in the same CUBE cycle → FAIL/11, step_cnt unchanged.
- Reset mid-CUBE: all outputs 0 next cycle; a subsequent run restarts cleanly; with the macro undefined, hist_rd_data is always 0.
